// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder: parameter legality and
// segment sizing used by pipelined_adder and adder_stage.
package adder_pkg;

    // WIDTH must be at least 2 and split evenly into STAGES ripple segments.
    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int unsigned seg_of(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered SEG-bit ripple slice. Operands shift right by SEG each stage so
// the slice always works on the low segment; finished sum bits enter from the top.
module adder_stage
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8,
    parameter type         stage_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t d,
    input  logic   adv,
    output logic   ready,
    output stage_t q
);

    logic [SEG:0]       seg_res;
    logic [WIDTH-1:0]   sum_next;
    stage_t             nxt;

    // Empty stages load even while downstream is stalled, so bubbles collapse.
    assign ready   = !q.valid || adv;
    assign seg_res = {1'b0, d.a_rem[SEG-1:0]} + {1'b0, d.b_rem[SEG-1:0]} + {{SEG{1'b0}}, d.carry};

    if (SEG == WIDTH) begin : g_whole
        assign sum_next = seg_res[SEG-1:0];
    end else begin : g_part
        assign sum_next = {seg_res[SEG-1:0], d.sum_done[WIDTH-1:SEG]};
    end

    always_comb begin
        nxt          = d;
        nxt.carry    = seg_res[SEG];
        nxt.a_rem    = d.a_rem >> SEG;
        nxt.b_rem    = d.b_rem >> SEG;
        nxt.sum_done = sum_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ready) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with the carry chain split over STAGES registered ripple slices,
// valid/ready on both sides and one result per cycle.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned SEG = seg_of(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    // Field widths follow WIDTH, so the stage record is declared per instance.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

    stage_t        pipe [STAGES+1];
    logic [STAGES:0] rdy;

    assign pipe[0] = '{valid:    in_valid,
                       carry:    in_cin,
                       a_rem:    in_a,
                       b_rem:    in_b,
                       sum_done: '0,
                       a_msb:    in_a[WIDTH-1],
                       b_msb:    in_b[WIDTH-1]};

    // rdy[k] is stage k's load enable; the chain runs back from out_ready.
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH   (WIDTH),
            .SEG     (SEG),
            .stage_t (stage_t)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .d     (pipe[k]),
            .adv   (rdy[k+1]),
            .ready (rdy[k]),
            .q     (pipe[k+1])
        );
    end

    assign out_valid = pipe[STAGES].valid;
    assign out_sum   = pipe[STAGES].sum_done;
    assign out_cout  = pipe[STAGES].carry;
    assign out_ovf   = (pipe[STAGES].a_msb == pipe[STAGES].b_msb) &&
                       (pipe[STAGES].sum_done[WIDTH-1] != pipe[STAGES].a_msb);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder in three configurations (32/4, 8/1, 8/8).
module tb_pipelined_adder;

    typedef struct {
        logic [33:0] res;
        int unsigned t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        in_cin;
    logic        out_ready;

    int          sel;
    int unsigned cfg_w, cfg_s;
    bit          chk_lat;
    int unsigned cycle = 0;
    int unsigned n_tests = 0, n_fail = 0, n_out = 0;
    exp_t        sb [$];

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic        co0, co1, co2, of0, of1, of2;
    logic [31:0] sum0;
    logic [7:0]  sum1, sum2;

    logic        cur_ready, cur_ov, cur_cout, cur_ovf;
    logic [31:0] cur_sum;

    always #5 clk = ~clk;

    initial forever @(posedge clk) cycle++;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov0), .out_ready(out_ready),
        .out_sum(sum0), .out_cout(co0), .out_ovf(of0));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .out_valid(ov1), .out_ready(out_ready),
        .out_sum(sum1), .out_cout(co1), .out_ovf(of1));

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .out_valid(ov2), .out_ready(out_ready),
        .out_sum(sum2), .out_cout(co2), .out_ovf(of2));

    always_comb begin
        cur_ready = 1'b0;
        cur_ov    = 1'b0;
        cur_sum   = '0;
        cur_cout  = 1'b0;
        cur_ovf   = 1'b0;
        case (sel)
            0: begin cur_ready = rdy0; cur_ov = ov0; cur_sum = sum0;          cur_cout = co0; cur_ovf = of0; end
            1: begin cur_ready = rdy1; cur_ov = ov1; cur_sum = {24'd0, sum1}; cur_cout = co1; cur_ovf = of1; end
            2: begin cur_ready = rdy2; cur_ov = ov2; cur_sum = {24'd0, sum2}; cur_cout = co2; cur_ovf = of2; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain full-width arithmetic reference, packed as {cout, ovf, sum}.
    function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        logic [32:0] full;
        logic [31:0] mask, s;
        logic        co, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, cin};
        s    = full[31:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {co, ov, s};
    endfunction

    // Monitor: handshakes are stable from posedge+1 to the next posedge.
    initial begin : monitor
        logic [33:0] obs, held;
        bit          stall_prev;
        exp_t        e;
        stall_prev = 0;
        held       = '0;
        forever begin
            @(negedge clk);
            obs = {cur_cout, cur_ovf, cur_sum};
            if (rst) begin
                sb.delete();
                stall_prev = 0;
            end else begin
                if (stall_prev) check("hold", {30'd0, obs}, {30'd0, held});
                if (in_valid && cur_ready) sb.push_back('{model(cfg_w, in_a, in_b, in_cin), cycle});
                if (cur_ov && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_output", {30'd0, obs}, 64'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        check("result", {30'd0, obs}, {30'd0, e.res});
                        if (chk_lat) check("latency", 64'(cycle - e.t), 64'(cfg_s));
                        n_out++;
                    end
                end
                stall_prev = cur_ov && !out_ready;
                held       = obs;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = cur_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_config(input int s_sel, input int unsigned w, input int unsigned s);
        logic [31:0] mask, smax, ba [8], bb [8];
        int unsigned idx, n0, exp_acc;
        bit          acc;
        sel     = s_sel;
        cfg_w   = w;
        cfg_s   = s;
        mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        smax    = mask >> 1;
        chk_lat = 1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        send(32'd1, 32'd2, 1'b0);      drain();
        send(mask, 32'd0, 1'b1);       drain();
        send(smax, 32'd1, 1'b0);
        send(smax + 32'd1, smax + 32'd1, 1'b0);
        drain();

        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a     = $urandom();
            in_b     = $urandom();
            in_cin   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stream_in_ready", {63'd0, cur_ready}, 1);
            @(posedge clk);
            #1;
        end
        drain();
        check("stream_count", 64'(n_out - n0), 16);

        // Backpressure: consumer stalled for 6 cycles while the source keeps offering.
        chk_lat = 0;
        n0      = n_out;
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom();
            bb[i] = $urandom();
        end
        out_ready = 1'b0;
        idx       = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_a     = ba[idx];
            in_b     = bb[idx];
            in_cin   = idx[0];
            @(negedge clk);
            acc = cur_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        exp_acc = (s < 6) ? s : 6;
        check("bp_accepts", 64'(idx), 64'(exp_acc));
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_in_ready", {63'd0, cur_ready}, (s > 6) ? 64'd1 : 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (idx < 8) begin
            send(ba[idx], bb[idx], idx[0]);
            idx++;
        end
        drain();
        check("bp_count", 64'(n_out - n0), 8);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        sel       = 0;
        cfg_w     = 32;
        cfg_s     = 4;
        chk_lat   = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ov_w32", {63'd0, ov0}, 0);
        check("rst_ov_s1",  {63'd0, ov1}, 0);
        check("rst_ov_s8",  {63'd0, ov2}, 0);
        check("rst_sum_w32", {32'd0, sum0}, 0);
        check("rst_flags_w32", {62'd0, co0, of0}, 0);
        check("rst_in_ready", {63'd0, rdy0}, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_config(0, 32, 4);

        // Reset with three transactions in flight; none may ever emerge.
        out_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b1);
        send(32'h5555_5555, 32'h6666_6666, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ov", {63'd0, cur_ov}, 0);
        check("post_rst_sum", {32'd0, cur_sum}, 0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", {63'd0, cur_ov}, 0);

        run_config(1, 8, 1);
        run_config(2, 8, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
